fpu_mul_pipe: RTL and testbench

Parametrised, fully pipelined IEEE-754-style floating-point multiplier. It is the next-generation datapath behind the FPU top-level multiply operator. The exponent and mantissa widths are generic; the default is binary32. It replaces the fixed-latency, no-backpressure result path with valid/ready handshakes on both sides. It also adds a pass-through tag, exception flags, round-to-nearest-even and flush-to-zero handling.

---
 rtl/fpu_pkg.sv | 22 ++
 rtl/fpu_unpack.sv | 35 +++
 rtl/fpu_mul_pipe.sv | 170 +++++++++++++++++
 tb/tb_fpu_mul_pipe.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: flag bit positions, operand classes, the multiply
// opcode used by the top-level decoder, and the canonical quiet-NaN pattern.
package fpu_pkg;

   localparam int FLG_INVALID   = 3;
   localparam int FLG_OVERFLOW  = 2;
   localparam int FLG_UNDERFLOW = 1;
   localparam int FLG_INEXACT   = 0;

   localparam logic [3:0] OP_MUL = 4'h2;

   typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_e;

   // Returns {0, all-ones exponent, 1, zeros} right-aligned in 128 bits;
   // callers size-cast it to their own word width.
   function automatic logic [127:0] qnan_bits(input int exp_w, input int man_w);
      logic [127:0] one;
      one = 128'd1;
      return ((one << (exp_w + man_w)) - (one << man_w)) | (one << (man_w - 1));
   endfunction

endpackage

// File: rtl/fpu_unpack.sv
// Splits one packed operand into sign, biased exponent, significand with
// hidden bit, and class. Denormal encodings are treated as zero.
module fpu_unpack
   import fpu_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic [EXP_W+MAN_W:0] op,
   output logic                 sign,
   output logic [EXP_W-1:0]     exp,
   output logic [MAN_W:0]       mant,
   output fp_class_e            cls
);

   logic exp_zero;
   logic exp_ones;
   logic frac_zero;

   assign sign      = op[EXP_W+MAN_W];
   assign exp       = op[EXP_W+MAN_W-1:MAN_W];
   assign exp_zero  = (exp == '0);
   assign exp_ones  = (exp == '1);
   assign frac_zero = (op[MAN_W-1:0] == '0);
   assign mant      = exp_zero ? '0 : {1'b1, op[MAN_W-1:0]};

   always_comb begin
      cls = NORM;
      if (exp_zero)
         cls = ZERO;
      else if (exp_ones)
         cls = frac_zero ? INF : NAN;
   end

endmodule

// File: rtl/fpu_mul_pipe.sv
// Three-stage floating-point multiplier (unpack/multiply, normalise,
// round/pack) with valid/ready on both sides and a pass-through tag.
module fpu_mul_pipe
   import fpu_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int TAG_W = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [EXP_W+MAN_W:0]   b,
   input  logic [TAG_W-1:0]       s_tag,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [EXP_W+MAN_W:0]   result,
   output logic [TAG_W-1:0]       m_tag,
   output logic [3:0]             flags
);

   localparam int W   = 1 + EXP_W + MAN_W;
   localparam int PW  = 2 * MAN_W + 2;
   localparam int EW2 = EXP_W + 2;

   localparam logic signed [EW2-1:0] BIAS     = EW2'((1 << (EXP_W - 1)) - 1);
   localparam logic signed [EW2-1:0] EMAX     = EW2'((1 << EXP_W) - 1);
   localparam logic signed [EW2-1:0] EXP_ONE  = EW2'(1);
   localparam logic signed [EW2-1:0] EXP_ZERO = EW2'(0);
   localparam logic [W-1:0]          QNAN     = W'(qnan_bits(EXP_W, MAN_W));

   logic s1_v, s2_v, s3_v;
   logic s1_load, s2_load, s3_load;

   assign s3_load = !s3_v || m_ready;
   assign s2_load = !s2_v || s3_load;
   assign s1_load = !s1_v || s2_load;
   assign s_ready = rst_n && s1_load;
   assign m_valid = s3_v;

   // S1: unpack, classify, exponent sum, significand product
   logic            sa, sb;
   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W:0]  ma, mb;
   fp_class_e       ca, cb;

   fpu_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
      .op(a), .sign(sa), .exp(ea), .mant(ma), .cls(ca)
   );
   fpu_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
      .op(b), .sign(sb), .exp(eb), .mant(mb), .cls(cb)
   );

   logic                   s1_nan, s1_inf, s1_zero, s1_sign;
   logic signed [EW2-1:0]  s1_exp;
   logic [PW-1:0]          s1_prod;
   logic [TAG_W-1:0]       s1_tag;

   always_ff @(posedge clk) begin
      if (s1_load && s_valid) begin
         s1_nan  <= (ca == NAN) || (cb == NAN) ||
                    (ca == INF && cb == ZERO) || (ca == ZERO && cb == INF);
         s1_inf  <= (ca == INF) || (cb == INF);
         s1_zero <= (ca == ZERO) || (cb == ZERO);
         s1_sign <= sa ^ sb;
         s1_exp  <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
         s1_prod <= {{(MAN_W+1){1'b0}}, ma} * {{(MAN_W+1){1'b0}}, mb};
         s1_tag  <= s_tag;
      end
   end

   // S2: normalise the product into [1,2) and collect guard/sticky
   logic [MAN_W-1:0]      norm_frac;
   logic                  norm_guard, norm_sticky;
   logic signed [EW2-1:0] norm_exp;

   always_comb begin
      norm_frac   = s1_prod[2*MAN_W-1 -: MAN_W];
      norm_guard  = s1_prod[MAN_W-1];
      norm_sticky = |s1_prod[MAN_W-2:0];
      norm_exp    = s1_exp;
      if (s1_prod[PW-1]) begin
         norm_frac   = s1_prod[2*MAN_W -: MAN_W];
         norm_guard  = s1_prod[MAN_W];
         norm_sticky = |s1_prod[MAN_W-1:0];
         norm_exp    = s1_exp + EXP_ONE;
      end
   end

   logic                  s2_nan, s2_inf, s2_zero, s2_sign;
   logic signed [EW2-1:0] s2_exp;
   logic [MAN_W-1:0]      s2_frac;
   logic                  s2_guard, s2_sticky;
   logic [TAG_W-1:0]      s2_tag;

   always_ff @(posedge clk) begin
      if (s2_load && s1_v) begin
         s2_nan    <= s1_nan;
         s2_inf    <= s1_inf;
         s2_zero   <= s1_zero;
         s2_sign   <= s1_sign;
         s2_exp    <= norm_exp;
         s2_frac   <= norm_frac;
         s2_guard  <= norm_guard;
         s2_sticky <= norm_sticky;
         s2_tag    <= s1_tag;
      end
   end

   // S3: round to nearest even; a carry out leaves the fraction all-zero
   logic                  round_inc;
   logic [MAN_W:0]        rnd_sum;
   logic signed [EW2-1:0] exp_fin;
   logic [W-1:0]          pack_res;
   logic [3:0]            pack_flags;

   assign round_inc = s2_guard && (s2_sticky || s2_frac[0]);
   assign rnd_sum   = {1'b0, s2_frac} + {{MAN_W{1'b0}}, round_inc};
   assign exp_fin   = s2_exp + (rnd_sum[MAN_W] ? EXP_ONE : EXP_ZERO);

   always_comb begin
      pack_res   = {s2_sign, exp_fin[EXP_W-1:0], rnd_sum[MAN_W-1:0]};
      pack_flags = '0;
      pack_flags[FLG_INEXACT] = s2_guard || s2_sticky;
      if (s2_nan) begin
         pack_res   = QNAN;
         pack_flags = '0;
         pack_flags[FLG_INVALID] = 1'b1;
      end else if (s2_inf) begin
         pack_res   = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         pack_flags = '0;
      end else if (s2_zero) begin
         pack_res   = {s2_sign, {(W-1){1'b0}}};
         pack_flags = '0;
      end else if (exp_fin >= EMAX) begin
         pack_res   = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         pack_flags = '0;
         pack_flags[FLG_OVERFLOW] = 1'b1;
         pack_flags[FLG_INEXACT]  = 1'b1;
      end else if (exp_fin <= EXP_ZERO) begin
         pack_res   = {s2_sign, {(W-1){1'b0}}};
         pack_flags = '0;
         pack_flags[FLG_UNDERFLOW] = 1'b1;
         pack_flags[FLG_INEXACT]   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_v   <= 1'b0;
         s2_v   <= 1'b0;
         s3_v   <= 1'b0;
         result <= '0;
         m_tag  <= '0;
         flags  <= '0;
      end else begin
         if (s1_load) s1_v <= s_valid;
         if (s2_load) s2_v <= s1_v;
         if (s3_load) s3_v <= s2_v;
         if (s3_load && s2_v) begin
            result <= pack_res;
            m_tag  <= s2_tag;
            flags  <= pack_flags;
         end
      end
   end

endmodule

// File: tb/tb_fpu_mul_pipe.sv
// Scoreboard bench for fpu_mul_pipe at binary32: directed cases, a stall
// stream, mid-flight reset, and randomized traffic against an integer model.
module tb_fpu_mul_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [3:0]  s_tag = '0;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic [31:0] result;
   logic [3:0]  m_tag;
   logic [3:0]  flags;

   fpu_mul_pipe dut (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid), .s_ready(s_ready), .a(a), .b(b), .s_tag(s_tag),
      .m_valid(m_valid), .m_ready(m_ready), .result(result), .m_tag(m_tag),
      .flags(flags)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] res;
      logic [3:0]  tag;
      logic [3:0]  flg;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        drv_exp;
   int          checks = 0;
   int          failures = 0;
   int          pops = 0;
   int          accepts = 0;
   bit          hold_pend = 0;
   logic [31:0] hold_res;
   logic [3:0]  hold_tag, hold_flg;
   bit          rnd_done = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, expv);
      end
   endtask

   // Reference: exact integer product, rounded by remainder comparison.
   function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] r, output logic [3:0] f);
      logic s, xz, yz, xi, yi, xn, yn;
      int ex, ey, e, n, sh;
      longint unsigned mx, my, p, q, rem, half;
      s  = x[31] ^ y[31];
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      xz = (ex == 0);
      yz = (ey == 0);
      xi = (ex == 255) && (x[22:0] == 0);
      yi = (ey == 255) && (y[22:0] == 0);
      xn = (ex == 255) && (x[22:0] != 0);
      yn = (ey == 255) && (y[22:0] != 0);
      f = 4'b0000;
      r = '0;
      if (xn || yn || (xi && yz) || (xz && yi)) begin
         r = 32'h7FC0_0000;
         f = 4'b1000;
      end else if (xi || yi) begin
         r = {s, 8'hFF, 23'h0};
      end else if (xz || yz) begin
         r = {s, 31'h0};
      end else begin
         mx = {40'h0, 1'b1, x[22:0]};
         my = {40'h0, 1'b1, y[22:0]};
         p  = mx * my;
         n  = (p >= (64'd1 << 47)) ? 47 : 46;
         sh = n - 23;
         q  = p >> sh;
         rem  = p - (q << sh);
         half = 64'd1 << (sh - 1);
         if (rem > half || (rem == half && q[0])) q = q + 1;
         e = ex + ey - 127 + n - 46;
         if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
         end
         if (e >= 255) begin
            r = {s, 8'hFF, 23'h0};
            f = 4'b0101;
         end else if (e <= 0) begin
            r = {s, 31'h0};
            f = 4'b0011;
         end else begin
            r = {s, 8'(e), q[22:0]};
            f = {3'b000, rem != 0};
         end
      end
   endfunction

   function automatic logic [31:0] rnd_op();
      int k;
      logic s;
      logic [7:0] e;
      logic [22:0] fr;
      k  = $urandom_range(0, 19);
      s  = 1'($urandom);
      fr = 23'($urandom);
      if (k == 0) e = 8'h00;
      else if (k == 1) begin e = 8'hFF; fr = '0; end
      else if (k == 2) begin e = 8'hFF; fr = fr | 23'h1; end
      else if (k < 8) e = 8'($urandom_range(1, 254));
      else e = 8'($urandom_range(90, 165));
      return {s, e, fr};
   endfunction

   // Input and output monitor: everything is sampled mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         sb_q.delete();
         hold_pend = 0;
      end else begin
         if (hold_pend) begin
            chk("stall_valid", {31'h0, m_valid}, 32'h1);
            chk("stall_result", result, hold_res);
            chk("stall_tag_flags", {24'h0, m_tag, flags}, {24'h0, hold_tag, hold_flg});
         end
         hold_pend = m_valid && !m_ready;
         hold_res  = result;
         hold_tag  = m_tag;
         hold_flg  = flags;
         if (m_valid && m_ready) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_output", result, 32'hxxxx_xxxx);
            end else begin
               e = sb_q.pop_front();
               chk("result", result, e.res);
               chk("tag", {28'h0, m_tag}, {28'h0, e.tag});
               chk("flags", {28'h0, flags}, {28'h0, e.flg});
               pops++;
            end
         end
         if (s_valid && s_ready) begin
            sb_q.push_back(drv_exp);
            accepts++;
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [31:0] oa, input logic [31:0] ob, input logic [3:0] tg,
                       input logic [31:0] er, input logic [3:0] ef);
      int n;
      n = 0;
      s_valid = 1'b1;
      a = oa;
      b = ob;
      s_tag = tg;
      drv_exp = '{res: er, tag: tg, flg: ef};
      do begin
         @(negedge clk);
         n++;
      end while (!s_ready && n < 200);
      if (!s_ready) chk("send_timeout", 32'h0, 32'h1);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
   endtask

   task automatic send_model(input logic [31:0] oa, input logic [31:0] ob, input logic [3:0] tg);
      logic [31:0] r;
      logic [3:0] f;
      model(oa, ob, r, f);
      send(oa, ob, tg, r, f);
   endtask

   task automatic check_latency(input string name);
      int lat;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!m_valid && lat < 10);
      chk(name, lat, 3);
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk(name, sb_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int pbase, abase, stale;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_m_valid", {31'h0, m_valid}, 32'h0);
      chk("rst_result", result, 32'h0);
      chk("rst_tag_flags", {24'h0, m_tag, flags}, 32'h0);
      chk("rst_s_ready", {31'h0, s_ready}, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_ready = 1'b1;

      // directed vectors with expectations taken straight from the rules
      send(32'h3FC0_0000, 32'h3FC0_0000, 4'd5, 32'h4010_0000, 4'b0000);
      check_latency("latency_first");
      wait_drain("drain_first");
      send(32'h3F80_0001, 32'h3FC0_0000, 4'd1, 32'h3FC0_0002, 4'b0001);
      send(32'h3F80_0001, 32'h3F80_0001, 4'd2, 32'h3F80_0002, 4'b0001);
      send(32'h7F80_0000, 32'h0000_0000, 4'd3, 32'h7FC0_0000, 4'b1000);
      send(32'hFF80_0000, 32'h4000_0000, 4'd4, 32'hFF80_0000, 4'b0000);
      send(32'h7F00_0000, 32'h7F00_0000, 4'd6, 32'h7F80_0000, 4'b0101);
      send(32'h0080_0000, 32'h3F00_0000, 4'd7, 32'h0000_0000, 4'b0011);
      send(32'h8000_0000, 32'h4000_0000, 4'd8, 32'h8000_0000, 4'b0000);
      send(32'h7FC0_1234, 32'h3F80_0000, 4'd9, 32'h7FC0_0000, 4'b1000);
      wait_drain("drain_directed");

      // six ops into a stalled output
      m_ready = 1'b0;
      pbase = pops;
      abase = accepts;
      fork
         begin
            for (int i = 0; i < 6; i++)
               send_model({1'b0, 8'($urandom_range(100, 150)), 23'($urandom)},
                          {1'b1, 8'($urandom_range(100, 150)), 23'($urandom)}, 4'(i));
         end
         begin
            repeat (4) @(posedge clk);
            @(negedge clk);
            chk("stall_s_ready", {31'h0, s_ready}, 32'h0);
            chk("stall_accepts", accepts - abase, 3);
            @(posedge clk);
            #1;
            m_ready = 1'b1;
         end
      join
      wait_drain("drain_stall");
      chk("stall_pops", pops - pbase, 6);

      // reset with two ops in flight
      send_model(32'h4040_0000, 32'h4040_0000, 4'hA);
      send_model(32'h4080_0000, 32'hC000_0000, 4'hB);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_s_ready", {31'h0, s_ready}, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_m_valid", {31'h0, m_valid}, 32'h0);
      chk("midrst_result", result, 32'h0);
      chk("midrst_flags", {28'h0, flags}, 32'h0);
      stale = 0;
      repeat (6) begin
         @(negedge clk);
         if (m_valid) stale++;
      end
      chk("midrst_no_stale", stale, 0);
      @(posedge clk);
      #1;
      send(32'h4040_0000, 32'h4000_0000, 4'hC, 32'h40C0_0000, 4'b0000);
      check_latency("latency_after_rst");
      wait_drain("drain_rst");

      // randomized traffic with random backpressure
      pbase = pops;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
               end
               send_model(rnd_op(), rnd_op(), 4'($urandom));
            end
            rnd_done = 1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1;
               m_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      m_ready = 1'b1;
      wait_drain("drain_random");
      chk("random_pops", pops - pbase, 300);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
